fpm_host_driver: RTL and testbench
==================================

Name: fpm_host_driver

Overview:
- Host-side counterpart of the floating-point multiplier's operand/result handshake.
- Buffers operand pairs in a small FIFO and runs one multiply transaction at a time: start pulse, operand handoff, result capture, done wait.
- Queues results in a second FIFO for the system side.
- Includes a watchdog that flags a hung multiplier.

Parameters:
- DEPTH, 4, entries in both the operand FIFO and the result FIFO; power of two, 2..16.
- TIMEOUT, 255, maximum cycles spent in any wait state before `err` is raised.

Ports:
- clk  in  1  clock; all flops rise-edge.
- rst  in  1  asynchronous, active-high reset.
- push  in  1  enqueue operand pair; ignored when `opFull`.
- pushA  in  32  IEEE-754 single operand A.
- pushB  in  32  IEEE-754 single operand B.
- opFull  out  1  operand FIFO full.
- pop  in  1  dequeue result; ignored when `!resValid`.
- popResult  out  32  head of result FIFO; valid while `resValid`.
- resValid  out  1  result FIFO non-empty.
- err  out  1  sticky watchdog error; cleared only by `rst`.
- startFP  out  1  one-cycle start pulse to the multiplier.
- A  out  32  operand A to the multiplier.
- B  out  32  operand B to the multiplier.
- inReady  out  1  operands valid.
- inAccept  in  1  multiplier took the operands.
- resultReady  in  1  multiplier result valid.
- result  in  32  multiplier result.
- resultAccepted  out  1  one-cycle result acknowledge.
- doneFP  in  1  multiplier finished the transaction.

Behaviour:
- Reset values: all outputs 0, both FIFOs empty, FSM in IDLE, watchdog counter 0, `err` 0.
- `A`/`B` are registered from the operand FIFO head on leaving IDLE and held stable until the next issue.
- Issue condition, evaluated in IDLE: operand FIFO non-empty AND (result count + 1) <= DEPTH. An in-flight result must always have a free slot.
- FSM states and transitions:
  - IDLE: on the issue condition, pop the operand FIFO, latch `A`/`B`, go to START.
  - START: `startFP`=1 for exactly this cycle; go to SEND.
  - SEND: `inReady`=1. When `inAccept` is sampled 1, deassert `inReady` next cycle and go to WAIT_RES.
  - WAIT_RES: when `resultReady` is sampled 1, write `result` into the result FIFO and go to ACK.
  - ACK: `resultAccepted`=1 for exactly this cycle; go to WAIT_DONE.
  - WAIT_DONE: on `doneFP`=1, go to IDLE.
- `doneFP` arriving in WAIT_RES or ACK is recorded in a flag. WAIT_DONE exits on the cycle after ACK if the flag is set.
- Minimum back-to-back issue period is 6 cycles (zero-latency multiplier).
- Watchdog:
  - Counter resets on every state change.
  - Counts in SEND, WAIT_RES and WAIT_DONE.
  - On reaching TIMEOUT: set `err`, force the FSM to IDLE, drop `inReady`, and discard the transaction (no result written).
- FIFOs:
  - Circular buffers with wrap-around pointers and a count of width clog2(DEPTH)+1.
  - Push on full is dropped silently; pop on empty is ignored.
  - Simultaneous push and pop on a full FIFO: the pop completes and the push is dropped.
  - Simultaneous push and pop on a non-full, non-empty FIFO: both complete, count unchanged.
  - Result FIFO: an FSM write and a user `pop` in the same cycle both complete.
  - `popResult` is combinational from the head entry.
- `rst` mid-transaction: immediate return to the reset state. Outstanding multiplier state is the system's responsibility; the multiplier shares `rst`.

Decomposition:
- Package fpm_pkg holds:
  - the state enum (IDLE, START, SEND, WAIT_RES, ACK, WAIT_DONE);
  - the FP32 field constants (SIGN_BIT=31, EXP_MSB=30, EXP_LSB=23, BIAS=127), shared with the multiplier.
- Sub-module sync_fifo (parameters WIDTH, DEPTH), instantiated twice: 64-bit operand FIFO and 32-bit result FIFO.

Test Plan:
- Single op: push A=0x40000000, B=0x40400000; multiplier model returns 0x40C00000 -> `startFP` pulses once, `inReady` holds until `inAccept`, `resultAccepted` is one cycle, `resValid`=1 with `popResult`=0x40C00000.
- Back-to-back: push 4 pairs with a zero-latency model -> issues spaced by exactly 6 cycles; results popped in order; `opFull`=1 after 4 pushes with no issue, and a 5th push is dropped.
- Backpressure: fill the result FIFO (4 results, no pop) with 1 more pair queued -> no `startFP` until one `pop`, then issue within 1 cycle.
- Early done: model asserts `doneFP` in the same cycle as `resultReady` -> the FSM still pulses `resultAccepted` and reaches IDLE the cycle after ACK.
- Hang: `inAccept` never asserted, TIMEOUT=255 -> `err`=1 after 255 SEND cycles, `inReady`=0, FSM in IDLE, result FIFO unchanged.
- Reset in WAIT_RES: `rst` pulsed -> all outputs 0 asynchronously, both FIFOs empty, `err`=0.

Source files
------------

// File: rtl/fpm_pkg.sv
// Shared definitions for the FP32 multiplier host driver.
//   state_t     : transaction sequencer states
//   FP32 fields : bit positions and exponent bias of IEEE-754 single,
//                 common to the driver and the multiplier datapath
package fpm_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    SEND      = 3'd2,
    WAIT_RES  = 3'd3,
    ACK       = 3'd4,
    WAIT_DONE = 3'd5
  } state_t;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int BIAS     = 127;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO.
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data; dropped when full (even with a same-cycle pop)
//   push_data  : WIDTH-bit write data
//   pop        : advance the read pointer; ignored when empty
//   head       : current head entry (combinational)
//   full/empty : occupancy flags derived from the entry count
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // Full check ignores a same-cycle pop: a push on a full FIFO is lost.
  assign do_push = push && !full;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fpm_host_driver.sv
// Host-side driver for the FP32 multiplier handshake.
// Queues operand pairs, runs one multiply transaction at a time and queues
// the results for the system side. A watchdog aborts a hung transaction.
//   clk, rst                  : clock, asynchronous active-high reset
//   push, pushA, pushB, opFull: operand pair enqueue side
//   pop, popResult, resValid  : result dequeue side
//   err                       : sticky watchdog error
//   startFP, A, B, inReady    : to multiplier (start pulse, operands, valid)
//   inAccept                  : multiplier took the operands
//   resultReady, result       : multiplier result valid / data
//   resultAccepted            : one-cycle result acknowledge
//   doneFP                    : multiplier finished the transaction
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | wait for operands and a free result slot
// START     | startFP pulse
// SEND      | inReady high until inAccept
// WAIT_RES  | wait for resultReady, capture result into result FIFO
// ACK       | resultAccepted pulse
// WAIT_DONE | wait for doneFP (or an early doneFP already seen)
module fpm_host_driver
  import fpm_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [31:0] pushA,
  input  logic [31:0] pushB,
  output logic        opFull,
  input  logic        pop,
  output logic [31:0] popResult,
  output logic        resValid,
  output logic        err,
  output logic        startFP,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic        inReady,
  input  logic        inAccept,
  input  logic        resultReady,
  input  logic [31:0] result,
  output logic        resultAccepted,
  input  logic        doneFP
);

  localparam int            WW      = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  state_t        state;
  logic [WW-1:0] wd_cnt;
  logic          done_seen;

  logic [63:0]   op_head;
  logic          op_full;
  logic          op_empty;
  logic [31:0]   res_head;
  logic          res_full;
  logic          res_empty;

  logic          issue;
  logic          res_wr;
  logic          wd_expired;

  // (result count + 1) <= DEPTH is exactly "result FIFO not full".
  assign issue      = (state == IDLE) && !op_empty && !res_full;
  assign res_wr     = (state == WAIT_RES) && resultReady;
  assign wd_expired = (wd_cnt == WD_LAST);

  sync_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_op_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({pushA, pushB}),
    .pop       (issue),
    .head      (op_head),
    .full      (op_full),
    .empty     (op_empty)
  );

  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_res_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (res_wr),
    .push_data (result),
    .pop       (pop),
    .head      (res_head),
    .full      (res_full),
    .empty     (res_empty)
  );

  assign opFull    = op_full;
  assign resValid  = !res_empty;
  assign popResult = res_empty ? 32'h0 : res_head;

  // wd_cnt defaults to zero every cycle, so any state change restarts it;
  // the waiting states only increment it while they hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      wd_cnt         <= '0;
      done_seen      <= 1'b0;
      err            <= 1'b0;
      startFP        <= 1'b0;
      inReady        <= 1'b0;
      resultAccepted <= 1'b0;
      A              <= '0;
      B              <= '0;
    end else begin
      startFP        <= 1'b0;
      resultAccepted <= 1'b0;
      wd_cnt         <= '0;
      case (state)
        IDLE: begin
          done_seen <= 1'b0;
          if (issue) begin
            A       <= op_head[63:32];
            B       <= op_head[31:0];
            startFP <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          inReady <= 1'b1;
          state   <= SEND;
        end
        SEND: begin
          if (inAccept) begin
            inReady <= 1'b0;
            state   <= WAIT_RES;
          end else if (wd_expired) begin
            inReady <= 1'b0;
            err     <= 1'b1;
            state   <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + WW'(1);
          end
        end
        WAIT_RES: begin
          if (doneFP) done_seen <= 1'b1;
          // A result arriving on the expiry cycle still wins over the abort.
          if (resultReady) begin
            resultAccepted <= 1'b1;
            state          <= ACK;
          end else if (wd_expired) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + WW'(1);
          end
        end
        ACK: begin
          if (doneFP) done_seen <= 1'b1;
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (doneFP || done_seen) begin
            state <= IDLE;
          end else if (wd_expired) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + WW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpm_host_driver.sv
`timescale 1ns/1ps
module tb_fpm_host_driver;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 255;

  logic        clk, rst;
  logic        push, pop;
  logic [31:0] pushA, pushB;
  logic        opFull, resValid, err, startFP, inReady, resultAccepted;
  logic [31:0] popResult, A, B, result;
  logic        inAccept, resultReady, doneFP;

  fpm_host_driver #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .push           (push),
    .pushA          (pushA),
    .pushB          (pushB),
    .opFull         (opFull),
    .pop            (pop),
    .popResult      (popResult),
    .resValid       (resValid),
    .err            (err),
    .startFP        (startFP),
    .A              (A),
    .B              (B),
    .inReady        (inReady),
    .inAccept       (inAccept),
    .resultReady    (resultReady),
    .result         (result),
    .resultAccepted (resultAccepted),
    .doneFP         (doneFP)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Stand-in multiplier function; the reference uses the same mapping,
  // so a mismatch points at operand latching or result queueing.
  function automatic logic [31:0] mul_ref(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
    return (a ^ {b[15:0], b[31:16]}) + 32'h1234_5678;
  endfunction

  // Multiplier model knobs: acc_lat < 0 means never accept.
  int acc_lat = 0;
  int res_lat = 0;
  bit early   = 1'b0;

  initial begin : mult_model
    int phase;
    int cnt;
    bit early_l;
    phase = 0; cnt = 0; early_l = 1'b0;
    inAccept = 1'b0; resultReady = 1'b0; result = '0; doneFP = 1'b0;
    forever begin
      @(posedge clk); #2;
      inAccept = 1'b0; resultReady = 1'b0; doneFP = 1'b0;
      if (rst) begin
        phase = 0; cnt = 0;
      end else begin
        case (phase)
          0: begin
            if (!inReady) cnt = 0;
            else if (acc_lat >= 0 && cnt >= acc_lat) begin
              inAccept = 1'b1; phase = 1; cnt = 0;
            end else cnt++;
          end
          1: begin
            if (cnt >= res_lat) begin
              resultReady = 1'b1;
              result      = mul_ref(A, B);
              early_l     = early;
              if (early_l) doneFP = 1'b1;
              phase = 2; cnt = 0;
            end else cnt++;
          end
          2: if (resultAccepted) phase = early_l ? 0 : 3;
          default: begin
            doneFP = 1'b1; phase = 0;
          end
        endcase
      end
    end
  end

  // Event monitor, sampled on the falling edge.
  int cyc        = 0;
  int start_q[$];
  int acc_pulses = 0;
  int acc_long   = 0;
  int st_long    = 0;
  int ready_cnt  = 0;
  logic prev_acc = 1'b0;
  logic prev_st  = 1'b0;

  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (startFP) start_q.push_back(cyc);
      if (startFP && prev_st) st_long++;
      if (resultAccepted && !prev_acc) acc_pulses++;
      if (resultAccepted && prev_acc) acc_long++;
      if (inReady) ready_cnt++;
      prev_acc = resultAccepted;
      prev_st  = startFP;
    end
  end

  initial begin : global_limit
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  logic [31:0] exp_q[$];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_push(input logic [31:0] a, input logic [31:0] b);
    push = 1'b1; pushA = a; pushB = b;
    tick();
    push = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    logic [31:0] e;
    e = exp_q.pop_front();
    check({tag, "_valid"}, resValid, 1);
    check(tag, popResult, e);
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  task automatic wait_acc(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (acc_pulses < target && n < budget) begin
      tick(); n++;
    end
    check(tag, acc_pulses, target);
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!resValid && n < budget) begin
      tick(); n++;
    end
  endtask

  initial begin : main
    int s0, s1, r0, a0, c;
    logic [31:0] a, b;

    rst = 1'b1; push = 1'b0; pop = 1'b0; pushA = '0; pushB = '0;
    repeat (3) tick();
    check("reset_ctrl", {startFP, inReady, resultAccepted, opFull, resValid, err}, 0);
    check("reset_A", A, 0);
    check("reset_B", B, 0);
    check("reset_popResult", popResult, 0);
    rst = 1'b0;
    repeat (2) tick();

    // Single operation
    s0 = start_q.size(); r0 = ready_cnt; a0 = acc_pulses;
    exp_q.push_back(32'h40C0_0000);
    do_push(32'h4000_0000, 32'h4040_0000);
    wait_acc("single_ack", a0 + 1, 50);
    repeat (2) tick();
    check("single_start_count", start_q.size() - s0, 1);
    check("single_inready_cycles", ready_cnt - r0, 1);
    check("single_A_held", A, 32'h4000_0000);
    check("single_B_held", B, 32'h4040_0000);
    pop_check("single_result");
    check("single_drained", resValid, 0);

    // Back-to-back, zero latency
    s0 = start_q.size(); a0 = acc_pulses;
    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = $urandom;
      exp_q.push_back(mul_ref(a, b));
      do_push(a, b);
    end
    wait_acc("b2b_acks", a0 + 4, 100);
    repeat (3) tick();
    check("b2b_start_count", start_q.size() - s0, 4);
    for (int i = 1; i < 4; i++) check("b2b_spacing", start_q[s0+i] - start_q[s0+i-1], 6);
    for (int i = 0; i < 4; i++) pop_check("b2b_result");

    // Backpressure: fill result FIFO, then queue 4 more plus a dropped 5th
    a0 = acc_pulses;
    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = $urandom;
      exp_q.push_back(mul_ref(a, b));
      do_push(a, b);
    end
    wait_acc("bp_fill_acks", a0 + 4, 100);
    repeat (3) tick();
    s1 = start_q.size();
    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = $urandom;
      exp_q.push_back(mul_ref(a, b));
      do_push(a, b);
      check("bp_opFull", opFull, (i == 3) ? 1 : 0);
    end
    do_push($urandom, $urandom);
    check("bp_opFull_after_drop", opFull, 1);
    repeat (20) tick();
    check("bp_no_issue_when_full", start_q.size() - s1, 0);
    pop_check("bp_result_first");
    c = cyc;
    begin
      int n;
      n = 0;
      while (start_q.size() == s1 && n < 10) begin
        tick(); n++;
      end
    end
    check("bp_issue_after_pop", (start_q.size() > s1) ? start_q[s1] : -1, c + 2);
    for (int i = 0; i < 7; i++) begin
      wait_valid(60);
      pop_check("bp_result");
    end
    wait_acc("bp_total_acks", a0 + 8, 60);
    repeat (10) tick();
    check("bp_fifth_dropped", resValid, 0);
    check("bp_start_total", start_q.size() - s1, 4);

    // Randomized latencies
    for (int k = 0; k < 8; k++) begin
      acc_lat = $urandom_range(0, 3);
      res_lat = $urandom_range(0, 4);
      early   = $urandom_range(0, 1);
      r0 = ready_cnt; a0 = acc_pulses;
      a = $urandom; b = $urandom;
      exp_q.push_back(mul_ref(a, b));
      do_push(a, b);
      wait_acc("rand_ack", a0 + 1, 60);
      repeat (2) tick();
      check("rand_inready_cycles", ready_cnt - r0, acc_lat + 1);
      pop_check("rand_result");
    end

    // Early done with zero latency: period stays 6
    acc_lat = 0; res_lat = 0; early = 1'b1;
    s0 = start_q.size(); a0 = acc_pulses;
    for (int i = 0; i < 2; i++) begin
      a = $urandom; b = $urandom;
      exp_q.push_back(mul_ref(a, b));
      do_push(a, b);
    end
    wait_acc("early_acks", a0 + 2, 60);
    repeat (3) tick();
    check("early_spacing", start_q[s0+1] - start_q[s0], 6);
    for (int i = 0; i < 2; i++) pop_check("early_result");
    check("pulse_widths", {acc_long[31:0], st_long[31:0]}, 0);
    early = 1'b0;

    // Hang: multiplier never accepts
    acc_lat = -1;
    r0 = ready_cnt;
    do_push($urandom, $urandom);
    begin
      int n;
      n = 0;
      while (!err && n < 400) begin
        tick(); n++;
      end
    end
    check("hang_err", err, 1);
    check("hang_send_cycles", ready_cnt - r0, TIMEOUT);
    check("hang_inready_low", inReady, 0);
    check("hang_no_result", resValid, 0);
    acc_lat = 0;
    a0 = acc_pulses;
    a = $urandom; b = $urandom;
    exp_q.push_back(mul_ref(a, b));
    do_push(a, b);
    wait_acc("hang_recover_ack", a0 + 1, 60);
    repeat (2) tick();
    check("hang_err_sticky", err, 1);
    pop_check("hang_recover_result");

    // Reset during WAIT_RES with both FIFOs occupied
    a0 = acc_pulses;
    a = $urandom; b = $urandom;
    exp_q.push_back(mul_ref(a, b));
    do_push(a, b);
    wait_acc("prereset_ack", a0 + 1, 60);
    repeat (2) tick();
    check("prereset_valid", resValid, 1);
    res_lat = 100;
    do_push($urandom, $urandom);
    do_push($urandom, $urandom);
    repeat (8) tick();
    #3 rst = 1'b1;
    #1;
    check("rst_async_ctrl", {startFP, inReady, resultAccepted, opFull, resValid, err}, 0);
    check("rst_async_AB", {A, B}, 0);
    check("rst_async_popResult", popResult, 0);
    @(posedge clk); @(posedge clk); #3 rst = 1'b0;
    exp_q.delete();
    res_lat = 0;
    tick();
    s0 = start_q.size();
    repeat (20) tick();
    check("rst_op_fifo_empty", start_q.size() - s0, 0);
    check("rst_res_fifo_empty", resValid, 0);
    a0 = acc_pulses;
    a = $urandom; b = $urandom;
    exp_q.push_back(mul_ref(a, b));
    do_push(a, b);
    wait_acc("postreset_ack", a0 + 1, 60);
    repeat (2) tick();
    pop_check("postreset_result");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
